serial_to_word: RTL
===================

Name: serial_to_word

Overview:
- Serial-to-parallel deserializer that sits directly upstream of the W-bit bit-reversal stage.
- Collects a 1-bit serial stream LSB-first into a W-bit word and presents it on a valid/ready output port. That port feeds the reversal stage's din.
- Double-buffered: shift register plus output holding register, so collection of the next word overlaps with a stalled output.

Parameters:
- W, 16, word width in bits (W >= 2); must match the downstream reversal stage width.

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of the partial word in the shift register
- s_valid  input  1  serial bit valid
- s_bit  input  1  serial data bit
- s_ready  output  1  block can accept a bit this cycle
- m_valid  output  1  m_data holds a complete word
- m_data  output  W  assembled word; first received bit at m_data[0]
- m_ready  input  1  downstream accepts the word
- m_perr  output  1  parity error for the word on m_data (see Optional Feature)
- bit_cnt  output  $clog2(W+1)  bits held in the shift register

Behaviour:
- Reset (rst_n low, asynchronous):
  - Outputs: m_valid=0, m_data=0, m_perr=0, bit_cnt=0.
  - Internal: state=COLLECT, shift register=0.
  - s_ready=1 once rst_n is high.
- Bit accept: s_valid && s_ready at a rising edge stores s_bit at position bit_cnt, then bit_cnt increments.
- States:
  - COLLECT: s_ready=1.
  - PEND: a full word is waiting and the output slot is occupied; s_ready=0.
- Slot free: m_valid==0, or m_valid && m_ready in this cycle.
- Word completion, on the edge accepting bit W-1:
  - Slot free: m_data <= assembled word, m_valid <= 1, bit_cnt <= 0, stay in COLLECT.
  - Slot not free: go to PEND and hold the word; bit_cnt reads W.
- PEND -> COLLECT: on the first edge with m_valid && m_ready, the pending word loads into m_data, m_valid stays 1, bit_cnt <= 0.
- Latency: m_valid rises one edge after the last bit is accepted (one cycle, registered output).
- Output drop: m_valid && m_ready with no word completing on that edge sets m_valid <= 0. m_data holds its value, and is don't-care when m_valid=0.
- Simultaneous handshake and completion: the new word replaces the consumed one and m_valid stays 1, giving back-to-back words with no bubble.
- flush: clears the shift register and bit_cnt in COLLECT. In PEND it is ignored, since the word is already complete. flush never affects m_valid or m_data. A bit offered in the same cycle as flush is dropped.
- Stability: m_data and m_perr change only when a new word is loaded, so they stay stable while m_valid && !m_ready.
- s_valid low: no state change; gaps between bits are allowed anywhere in a word.
- Reset mid-word or in PEND: everything in flight is discarded; no partial word is ever output.

Optional Feature:
- Macro: SER2W_PARITY_EN.
- Defined:
  - After data bit W-1, one extra serial bit is accepted as the even-parity bit; bit_cnt reads W during this phase.
  - Word completion happens on the parity-bit edge, not on bit W-1.
  - m_perr is loaded with the word: 1 when XOR(data bits, parity bit) != 0.
- Not defined: W bits per word, and m_perr is tied to 0. The port list is identical in both builds.

Test Plan:
- W=16, m_ready=1, send 16'b1000000001111000 LSB-first, one bit per cycle -> m_valid pulses for 1 cycle, 1 cycle after the 16th bit, with m_data=16'h8078.
- Two words back-to-back (16'hF000 then 16'h8007), m_ready held 0 until 20 cycles after the second word completes:
  - m_data=16'hF000 held stable while stalled.
  - s_ready=0 and bit_cnt=16 once the second word completes.
  - m_ready=1 -> 16'h8007 loads the next edge with no bubble, then s_ready=1.
- Random s_valid gaps, 50% duty, word 16'hA5C3 -> m_data=16'hA5C3; bit_cnt tracks the accepted-bit count exactly.
- Send 7 bits, assert flush 1 cycle, then send 16'h0001 -> m_data=16'h0001 and bit_cnt returns to 0.
- Assert rst_n low after 9 bits, release, send 16'h1234 -> m_valid stays 0 until the word completes; m_data=16'h1234.
- SER2W_PARITY_EN, send 16'h0003 with parity 0 -> m_perr=0; send 16'h0003 with parity 1 -> m_perr=1; 17 accepted bits per word.

Source files
------------

// File: rtl/serial_to_word.sv
// serial_to_word: LSB-first serial-to-parallel deserializer with double-buffered valid/ready output.
// Optional macro SER2W_PARITY_EN appends an even-parity bit per word and reports m_perr.
module serial_to_word #(
    parameter int W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     s_valid,
    input  logic                     s_bit,
    output logic                     s_ready,
    output logic                     m_valid,
    output logic [W-1:0]             m_data,
    input  logic                     m_ready,
    output logic                     m_perr,
    output logic [$clog2(W+1)-1:0]   bit_cnt
);
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] FULL = CW'(W);
`ifdef SER2W_PARITY_EN
    localparam logic [CW-1:0] LAST = CW'(W);
`else
    localparam logic [CW-1:0] LAST = CW'(W - 1);
`endif
    typedef enum logic {COLLECT, PEND} state_t;
    state_t state, state_nx;
    logic [W-1:0] sr, word;
    logic acc, done, slot_free, release_pend, perr, pend_perr;
    assign slot_free    = !m_valid || m_ready;
    assign acc          = s_valid && s_ready && !flush;
    assign done         = acc && bit_cnt == LAST;
    assign release_pend = state == PEND && m_valid && m_ready;
    // during the parity phase bit_cnt is W, so the shift contributes nothing
    assign word         = sr | (W'(s_bit) << bit_cnt);
`ifdef SER2W_PARITY_EN
    assign perr = ^sr ^ s_bit;
`else
    assign perr = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= COLLECT;
        else        state <= state_nx;
    always_comb
        state_nx = (state == COLLECT) ? ((done && !slot_free) ? PEND : COLLECT)
                                      : (release_pend ? COLLECT : PEND);
    always_comb
        s_ready = state == COLLECT;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_perr    <= 1'b0;
            sr        <= '0;
            bit_cnt   <= '0;
            pend_perr <= 1'b0;
        end else begin
            if ((done && slot_free) || release_pend) m_valid <= 1'b1;
            else if (m_ready)                        m_valid <= 1'b0;
            if (done && slot_free) begin
                m_data <= word;
                m_perr <= perr;
            end else if (release_pend) begin
                m_data <= sr;
                m_perr <= pend_perr;
            end
            if (release_pend) begin
                sr      <= '0;
                bit_cnt <= '0;
            end else if (state == COLLECT) begin
                if (flush) begin
                    sr      <= '0;
                    bit_cnt <= '0;
                end else if (done && slot_free) begin
                    sr      <= '0;
                    bit_cnt <= '0;
                end else if (done) begin
                    sr        <= word;
                    bit_cnt   <= FULL;
                    pend_perr <= perr;
                end else if (acc) begin
                    sr      <= word;
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end
endmodule
